// File: rtl/ub_stream_reader.sv
// rtl/ub_stream_reader.sv - unified buffer port-0 row reader with credit-limited issue and output FIFO
module ub_stream_reader #(
    parameter int MATRIX_WIDTH = 14,
    parameter int TILE_WIDTH   = 4096,
    parameter int READ_LATENCY = 3,
    parameter int FIFO_DEPTH   = 4,
    parameter int CNT_WIDTH    = 13,
    parameter int ADDR_WIDTH   = $clog2(TILE_WIDTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [ADDR_WIDTH-1:0]        start_address,
    input  logic [CNT_WIDTH-1:0]         row_count,
    output logic                         ub_enable,
    output logic                         ub_en0,
    output logic [ADDR_WIDTH-1:0]        ub_address0,
    input  logic [MATRIX_WIDTH-1:0][7:0] ub_read_port0,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [MATRIX_WIDTH-1:0][7:0] out_data,
    output logic                         out_last,
    output logic                         busy,
    output logic                         done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CW    = $clog2(FIFO_DEPTH + 1);
    localparam int IF_W  = $clog2(READ_LATENCY + 1);
    localparam int SW    = CW + IF_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]   hold_addr_q, hold_addr_d;
    logic [CNT_WIDTH-1:0]    remaining_q, remaining_d;
    logic                    done_zero_q, done_zero_d;
    logic                    ub_enable_q;
    logic [READ_LATENCY-1:0] pipe_q, pipe_d;
    logic [READ_LATENCY-1:0] pipe_last_q, pipe_last_d;

    logic [FIFO_DEPTH-1:0][MATRIX_WIDTH-1:0][7:0] mem_q, mem_d;
    logic [FIFO_DEPTH-1:0]   last_mem_q, last_mem_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           fifo_count_q, fifo_count_d;

    logic [IF_W-1:0]         inflight;
    logic                    pop;
    logic                    push;
    logic                    credit_ok;
    logic                    issue;
    logic                    drain_done;
    logic [CNT_WIDTH-1:0]    cnt_clamped;

    // Count reads still travelling through the buffer's latency pipe
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + IF_W'(pipe_q[i]);
        end
    end

    // Issue only when the row is guaranteed a FIFO slot on arrival
    always_comb begin
        pop        = (fifo_count_q != '0) && out_ready;
        push       = pipe_q[READ_LATENCY-1];
        credit_ok  = (SW'(fifo_count_q) + SW'(inflight) - SW'(pop)) < SW'(FIFO_DEPTH);
        issue      = (state_q == ST_ISSUE) && credit_ok;
        drain_done = (state_q == ST_DRAIN) && (inflight == '0) && (fifo_count_q == '0);
    end

    // Command FSM: latch command, walk addresses, wait for the pipe and FIFO to empty
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        hold_addr_d = hold_addr_q;
        remaining_d = remaining_q;
        done_zero_d = 1'b0;
        cnt_clamped = (row_count > CNT_WIDTH'(TILE_WIDTH)) ? CNT_WIDTH'(TILE_WIDTH) : row_count;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_d      = start_address;
                    remaining_d = cnt_clamped;
                    if (cnt_clamped == '0) begin
                        done_zero_d = 1'b1;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (issue) begin
                    hold_addr_d = addr_q;
                    addr_d      = (addr_q == ADDR_WIDTH'(TILE_WIDTH - 1)) ? '0 : addr_q + ADDR_WIDTH'(1);
                    remaining_d = remaining_q - CNT_WIDTH'(1);
                    if (remaining_q == CNT_WIDTH'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Shift issue bits and last flags through a model of the buffer latency
    always_comb begin
        pipe_d         = '0;
        pipe_last_d    = '0;
        pipe_d[0]      = issue;
        pipe_last_d[0] = issue && (remaining_q == CNT_WIDTH'(1));
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_d[i]      = pipe_q[i-1];
            pipe_last_d[i] = pipe_last_q[i-1];
        end
    end

    // Output FIFO: capture returning rows, present the head to the consumer
    always_comb begin
        mem_d        = mem_q;
        last_mem_d   = last_mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_count_d = fifo_count_q;
        if (push) begin
            mem_d[wr_ptr_q]      = ub_read_port0;
            last_mem_d[wr_ptr_q] = pipe_last_q[READ_LATENCY-1];
            wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   fifo_count_d = fifo_count_q + CW'(1);
            2'b01:   fifo_count_d = fifo_count_q - CW'(1);
            default: fifo_count_d = fifo_count_q;
        endcase
    end

    // State registers; reset discards any reads still in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            hold_addr_q  <= '0;
            remaining_q  <= '0;
            done_zero_q  <= 1'b0;
            ub_enable_q  <= 1'b0;
            pipe_q       <= '0;
            pipe_last_q  <= '0;
            mem_q        <= '0;
            last_mem_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            hold_addr_q  <= hold_addr_d;
            remaining_q  <= remaining_d;
            done_zero_q  <= done_zero_d;
            ub_enable_q  <= 1'b1;
            pipe_q       <= pipe_d;
            pipe_last_q  <= pipe_last_d;
            mem_q        <= mem_d;
            last_mem_q   <= last_mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
        end
    end

    assign cmd_ready   = (state_q == ST_IDLE);
    assign ub_enable   = ub_enable_q;
    assign ub_en0      = issue;
    assign ub_address0 = issue ? addr_q : hold_addr_q;
    assign out_valid   = (fifo_count_q != '0);
    assign out_data    = mem_q[rd_ptr_q];
    assign out_last    = out_valid && last_mem_q[rd_ptr_q];
    assign busy        = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    assign done        = done_zero_q || drain_done;

endmodule
